// File: rtl/spi_cmd_if.sv
// spi_cmd_if: command/response handshake between a host and spi_cmd_master.
interface spi_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [9:0] cmd_word;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  modport master(output cmd_valid, cmd_rw, cmd_word, input cmd_ready, rsp_valid, rsp_data);
  modport slave(input cmd_valid, cmd_rw, cmd_word, output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: frames host command words onto SS_n/MOSI (one bit per clk) and captures read bytes from MISO.
module spi_cmd_master #(
  parameter int POST_HOLD = 2,
  parameter int RD_LAT    = 2,
  parameter int RD_BITS   = 8,
  parameter int IDLE_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_cmd_if.slave    cmd,
  output logic        busy,
  output logic        SS_n,
  output logic        MOSI,
  input  logic        MISO
);
  typedef enum logic [2:0] {IDLE, CMD, SHIFT, HOLD, RD_WAIT, RD_CAP, GAP} state_t;
  state_t      state, nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        rw;
  logic [9:0]  word;
  logic [7:0]  sr, sr_nxt;
  logic        accept, cap, ss_nxt, mosi_nxt, done;
  assign accept = state == IDLE && cmd.cmd_valid && cmd.cmd_ready;
  assign cap    = rw && word[9:8] == 2'b11;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? CMD : IDLE;
      CMD:     nxt = SHIFT;
      SHIFT:   if (cnt == 4'd9) nxt = cap ? (RD_LAT == 0 ? RD_CAP : RD_WAIT) : (POST_HOLD == 0 ? GAP : HOLD);
      HOLD:    if (int'(cnt) == POST_HOLD - 1) nxt = GAP;
      RD_WAIT: if (int'(cnt) == RD_LAT - 1) nxt = RD_CAP;
      RD_CAP:  if (int'(cnt) == RD_BITS - 1) nxt = GAP;
      GAP:     if (int'(cnt) == IDLE_GAP - 1) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    cnt_nxt  = nxt == state ? cnt + 4'd1 : 4'd0;
    sr_nxt   = state == RD_CAP ? (sr >> 1) | (8'(MISO) << (RD_BITS - 1)) : sr;
    done     = state == RD_CAP && nxt == GAP;
    ss_nxt   = nxt == IDLE || nxt == GAP;
    mosi_nxt = nxt == CMD ? cmd.cmd_rw : nxt == SHIFT ? word[cnt_nxt] : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rw    <= 1'b0;
      word  <= '0;
      sr    <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      if (accept) begin
        rw   <= cmd.cmd_rw;
        word <= cmd.cmd_word;
      end
    end
  // Every output is registered from the next-state view, so it lines up with the state it describes.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      SS_n          <= 1'b1;
      MOSI          <= 1'b0;
      busy          <= 1'b0;
      cmd.cmd_ready <= 1'b0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_data  <= '0;
    end else begin
      SS_n          <= ss_nxt;
      MOSI          <= mosi_nxt;
      busy          <= nxt != IDLE;
      cmd.cmd_ready <= nxt == IDLE;
      cmd.rsp_valid <= done;
      if (done) cmd.rsp_data <= sr_nxt;
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: randomized frames on two parameterizations checked against a per-cycle frame model.
module tb_spi_cmd_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_cmd_if ia();
  spi_cmd_if ib();
  logic ss_a, mosi_a, busy_a, ss_b, mosi_b, busy_b;
  logic miso_a = 1'b0;
  logic miso_b = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [7:0] last_rsp [2] = '{8'h00, 8'h00};
  spi_cmd_master #(.POST_HOLD(2), .RD_LAT(2), .RD_BITS(8), .IDLE_GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd(ia.slave), .busy(busy_a), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso_a));
  spi_cmd_master #(.POST_HOLD(2), .RD_LAT(0), .RD_BITS(8), .IDLE_GAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd(ib.slave), .busy(busy_b), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b));

  task automatic set_cmd(input bit sel, input logic v, input logic rw, input logic [9:0] w);
    if (sel) begin ib.cmd_valid = v; ib.cmd_rw = rw; ib.cmd_word = w; end
    else     begin ia.cmd_valid = v; ia.cmd_rw = rw; ia.cmd_word = w; end
  endtask

  // One complete frame from accept to the next IDLE cycle; model derived from frame-length rules.
  task automatic run_frame(input bit sel, input bit rw, input logic [9:0] word, input logic [7:0] rb, input bit hold);
    int rl, g, len, n;
    bit cap;
    logic e_ss, e_mo, e_bu, e_rd, e_rv, o_ss, o_mo, o_bu, o_rd, o_rv, m;
    logic [7:0] o_rdata;
    rl  = sel ? 0 : 2;
    g   = sel ? 1 : 2;
    cap = rw && word[9:8] == 2'b11;
    len = 11 + (cap ? rl + 8 : 2);
    set_cmd(sel, 1'b1, rw, word);
    n = 0;
    while (!(sel ? ib.cmd_ready : ia.cmd_ready) && n < 40) begin @(negedge clk); n++; end
    tests++;
    if (!(sel ? ib.cmd_ready : ia.cmd_ready)) begin
      fails++;
      $display("FAIL accept_wait dut=%0d cmd_ready=0 required 1", sel);
      set_cmd(sel, 1'b0, 1'b0, 10'h0);
      return;
    end
    for (int k = 1; k <= len + g + 1; k++) begin
      @(negedge clk);
      m = (cap && k >= 12 + rl && k < 20 + rl) ? rb[k - 12 - rl] : 1'($urandom);
      if (sel) miso_b = m; else miso_a = m;
      if (k == 1) set_cmd(sel, hold, 1'($urandom), 10'($urandom));
      if (cap && k == len + 1) last_rsp[sel] = rb;
      e_ss = k > len;
      e_mo = k == 1 ? rw : (k >= 2 && k <= 11) ? word[k - 2] : 1'b0;
      e_bu = k <= len + g;
      e_rd = k == len + g + 1;
      e_rv = cap && k == len + 1;
      o_ss = sel ? ss_b : ss_a;
      o_mo = sel ? mosi_b : mosi_a;
      o_bu = sel ? busy_b : busy_a;
      o_rd = sel ? ib.cmd_ready : ia.cmd_ready;
      o_rv = sel ? ib.rsp_valid : ia.rsp_valid;
      o_rdata = sel ? ib.rsp_data : ia.rsp_data;
      tests += 6;
      if (o_ss !== e_ss) begin fails++; $display("FAIL ss_n dut=%0d k=%0d got %b exp %b", sel, k, o_ss, e_ss); end
      if (o_mo !== e_mo) begin fails++; $display("FAIL mosi dut=%0d k=%0d got %b exp %b", sel, k, o_mo, e_mo); end
      if (o_bu !== e_bu) begin fails++; $display("FAIL busy dut=%0d k=%0d got %b exp %b", sel, k, o_bu, e_bu); end
      if (o_rd !== e_rd) begin fails++; $display("FAIL cmd_ready dut=%0d k=%0d got %b exp %b", sel, k, o_rd, e_rd); end
      if (o_rv !== e_rv) begin fails++; $display("FAIL rsp_valid dut=%0d k=%0d got %b exp %b", sel, k, o_rv, e_rv); end
      if (o_rdata !== last_rsp[sel]) begin fails++; $display("FAIL rsp_data dut=%0d k=%0d got %h exp %h", sel, k, o_rdata, last_rsp[sel]); end
    end
  endtask

  task automatic test_reset;
    set_cmd(0, 1'b0, 1'b0, 10'h0);
    set_cmd(1, 1'b0, 1'b0, 10'h0);
    repeat (3) @(negedge clk);
    tests += 6;
    if (ss_a !== 1'b1)          begin fails++; $display("FAIL reset_ss_n got %b exp 1", ss_a); end
    if (mosi_a !== 1'b0)        begin fails++; $display("FAIL reset_mosi got %b exp 0", mosi_a); end
    if (ia.cmd_ready !== 1'b0)  begin fails++; $display("FAIL reset_cmd_ready got %b exp 0", ia.cmd_ready); end
    if (busy_a !== 1'b0)        begin fails++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    if (ia.rsp_valid !== 1'b0)  begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", ia.rsp_valid); end
    if (ia.rsp_data !== 8'h00)  begin fails++; $display("FAIL reset_rsp_data got %h exp 00", ia.rsp_data); end
    rst_n = 1'b1;
    @(negedge clk);
    tests += 2;
    if (ia.cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset dut=0 got %b exp 1", ia.cmd_ready); end
    if (ib.cmd_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset dut=1 got %b exp 1", ib.cmd_ready); end
  endtask

  task automatic test_write;      run_frame(0, 1'b0, 10'h0A5, 8'h00, 0); endtask
  task automatic test_read_addr;  run_frame(0, 1'b1, 10'h2F0, 8'h00, 0); endtask
  task automatic test_read_data;  run_frame(0, 1'b1, 10'h300, 8'hC3, 0); endtask

  task automatic test_back_to_back;
    run_frame(0, 1'b0, 10'($urandom), 8'h00, 1);
    run_frame(0, 1'b1, {2'b11, 8'($urandom)}, 8'($urandom), 1);
    run_frame(0, 1'b1, {2'b01, 8'($urandom)}, 8'h00, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++)
      run_frame(1'($urandom), 1'($urandom), {($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom), 8'($urandom)},
                8'($urandom), 1'($urandom));
    set_cmd(0, 1'b0, 1'b0, 10'h0);
    set_cmd(1, 1'b0, 1'b0, 10'h0);
  endtask

  task automatic test_reset_mid_capture;
    logic [7:0] rb;
    rb = 8'($urandom) | 8'h10;
    run_frame(0, 1'b1, 10'h3A5, 8'h5A, 0);
    set_cmd(0, 1'b1, 1'b1, 10'h3C0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) set_cmd(0, 1'b0, 1'b0, 10'h0);
      miso_a = k >= 14 ? rb[k - 14] : 1'($urandom);
    end
    tests++;
    if (ss_a !== 1'b0) begin fails++; $display("FAIL pre_reset_in_capture ss_n got %b exp 0", ss_a); end
    rst_n = 1'b0;
    #1;
    tests += 4;
    if (ss_a !== 1'b1)         begin fails++; $display("FAIL midreset_ss_n got %b exp 1", ss_a); end
    if (ia.rsp_valid !== 1'b0) begin fails++; $display("FAIL midreset_rsp_valid got %b exp 0", ia.rsp_valid); end
    if (ia.rsp_data !== 8'h00) begin fails++; $display("FAIL midreset_rsp_data got %h exp 00", ia.rsp_data); end
    if (busy_a !== 1'b0)       begin fails++; $display("FAIL midreset_busy got %b exp 0", busy_a); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rsp[0] = 8'h00;
    last_rsp[1] = 8'h00;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      miso_a = 1'($urandom);
      tests += 3;
      if (ia.rsp_valid !== 1'b0) begin fails++; $display("FAIL post_reset_rsp_valid k=%0d got %b exp 0", k, ia.rsp_valid); end
      if (ia.rsp_data !== 8'h00) begin fails++; $display("FAIL post_reset_rsp_data k=%0d got %h exp 00", k, ia.rsp_data); end
      if (ss_a !== 1'b1)         begin fails++; $display("FAIL post_reset_ss_n k=%0d got %b exp 1", k, ss_a); end
    end
    run_frame(0, 1'b1, {2'b11, 8'($urandom)}, 8'($urandom), 0);
  endtask

  task automatic test_sweep;
    run_frame(1, 1'b1, {2'b11, 8'($urandom)}, 8'($urandom), 1);
    run_frame(1, 1'b0, 10'($urandom), 8'h00, 1);
    run_frame(1, 1'b1, {2'b11, 8'($urandom)}, 8'($urandom), 0);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read_addr;
    test_read_data;
    test_back_to_back;
    test_random;
    test_reset_mid_capture;
    test_sweep;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end
endmodule
